// File: rtl/bec_pkg.sv
// Shared definitions for the binary Edwards curve datapath: field defaults,
// FSM encoding and the operand type used by the LA front end.
package bec_pkg;

  localparam int          DEFAULT_M    = 16;
  localparam logic [15:0] DEFAULT_POLY = 16'h002B;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b11,
    DONE = 2'b10
  } mult_state_t;

  typedef logic [DEFAULT_M-1:0] operand_t;

endpackage

// File: rtl/bec_gf2m_mulx_step.sv
// One MSB-first GF(2^M) step: multiply the accumulator by x, reduce by POLY,
// then add A when the current bit of B is set.
module bec_gf2m_mulx_step
  import bec_pkg::*;
#(
  parameter int           M    = DEFAULT_M,
  parameter logic [M-1:0] POLY = DEFAULT_POLY
) (
  input  logic [M-1:0] c,
  input  logic [M-1:0] a,
  input  logic         b_bit,
  output logic [M-1:0] c_next
);

  logic [M-1:0] shifted;

  always_comb begin
    shifted = {c[M-2:0], 1'b0} ^ (c[M-1] ? POLY : '0);
    c_next  = shifted ^ (b_bit ? a : '0);
  end

endmodule

// File: rtl/bec_gf2m_serial_mult.sv
// Bit-serial GF(2^M) multiplier, the first arithmetic stage of the BEC datapath.
// Define BEC_GFM_DIGIT2_EN to consume two bits of B per clock (M must be even).
module bec_gf2m_serial_mult
  import bec_pkg::*;
#(
  parameter int           M    = DEFAULT_M,
  parameter logic [M-1:0] POLY = DEFAULT_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [M-1:0] op_a_i,
  input  logic [M-1:0] op_b_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [M-1:0] result_o
);

`ifdef BEC_GFM_DIGIT2_EN
  localparam int DIGIT = 2;
  if (M % 2 != 0) begin : g_odd_m
    $error("bec_gf2m_serial_mult: M must be even when BEC_GFM_DIGIT2_EN is defined");
  end
`else
  localparam int DIGIT = 1;
`endif

  localparam int STEPS = M / DIGIT;
  localparam int CW    = $clog2(M);

  mult_state_t  state;
  logic [M-1:0] op_a;
  logic [M-1:0] op_b;
  logic [M-1:0] b_work;
  logic [M-1:0] acc;
  logic [M-1:0] acc_next;
  logic [M-1:0] step_hi;
  logic [CW-1:0] cnt;

  // b_work is a private copy of B shifted out MSB-first, so op_b stays intact.
  bec_gf2m_mulx_step #(.M(M), .POLY(POLY)) u_step_hi (
    .c      (acc),
    .a      (op_a),
    .b_bit  (b_work[M-1]),
    .c_next (step_hi)
  );

`ifdef BEC_GFM_DIGIT2_EN
  logic [M-1:0] step_lo;

  bec_gf2m_mulx_step #(.M(M), .POLY(POLY)) u_step_lo (
    .c      (step_hi),
    .a      (op_a),
    .b_bit  (b_work[M-2]),
    .c_next (step_lo)
  );

  assign acc_next = step_lo;
`else
  assign acc_next = step_hi;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      op_a     <= '0;
      op_b     <= '0;
      b_work   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            op_a <= op_a_i;
            op_b <= op_b_i;
          end
          if (start_i) begin
            state    <= RUN;
            busy_o   <= 1'b1;
            acc      <= '0;
            result_o <= '0;
            cnt      <= CW'(STEPS - 1);
            b_work   <= load_i ? op_b_i : op_b;
          end
        end
        RUN: begin
          acc    <= acc_next;
          b_work <= b_work << DIGIT;
          if (cnt == '0) begin
            state    <= DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= acc_next;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bec_gf2m_serial_mult.sv
// Directed and random self-checking bench for bec_gf2m_serial_mult (M=16, POLY=002B).
module tb_bec_gf2m_serial_mult;
  import bec_pkg::*;

`ifdef BEC_GFM_DIGIT2_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     load_i = 1'b0;
  logic     start_i = 1'b0;
  operand_t op_a_i = '0;
  operand_t op_b_i = '0;
  logic     busy_o;
  logic     done_o;
  operand_t result_o;

  int       check_count = 0;
  int       pass_count = 0;
  int       busy_cycles;
  int       done_cycle;
  int       done_pulses;
  operand_t res;
  operand_t res_early;
  operand_t ra;
  operand_t rb;

  bec_gf2m_serial_mult dut (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .start_i  (start_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Reference: full carry-less product, then long-division reduction by x^16+x^5+x^3+x+1.
  function automatic operand_t gf_ref(input operand_t a, input operand_t b);
    logic [30:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = p ^ (31'(a) << i);
    for (int k = 30; k >= 16; k--)
      if (p[k]) p = p ^ (31'(17'h1002B) << (k - 16));
    return p[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    else
      pass_count++;
  endtask

  // mode 0: load then start next cycle; 1: load and start together; 2: start only
  task applyStimulus(input operand_t a, input operand_t b, input int mode);
    int cyc;
    @(negedge clk);
    op_a_i  = a;
    op_b_i  = b;
    load_i  = (mode != 2);
    start_i = (mode != 0);
    if (mode == 0) begin
      @(negedge clk);
      load_i  = 1'b0;
      start_i = 1'b1;
    end
    @(negedge clk);
    load_i      = 1'b0;
    start_i     = 1'b0;
    busy_cycles = 0;
    done_cycle  = 0;
    res_early   = result_o;
    res         = 'x;
    cyc         = 1;
    while (cyc <= 40 && done_cycle == 0) begin
      if (busy_o) busy_cycles++;
      if (done_o) begin
        done_cycle = cyc;
        res        = result_o;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_result", 32'(result_o), 32'h0);

    applyStimulus(16'h8000, 16'h0002, 0);
    checkOutput("t1_busy_cycles", busy_cycles, LAT);
    checkOutput("t1_done_cycle", done_cycle, LAT + 1);
    checkOutput("t1_result", 32'(res), 32'h002B);
    @(negedge clk);
    checkOutput("t1_done_single", 32'(done_o), 32'd0);
    checkOutput("t1_result_held", 32'(result_o), 32'h002B);

    applyStimulus(16'h8000, 16'h8000, 0);
    checkOutput("t2_start_clears", 32'(res_early), 32'h0);
    checkOutput("t2_done_cycle", done_cycle, LAT + 1);
    checkOutput("t2_result", 32'(res), 32'hC10E);

    applyStimulus(16'h1234, 16'h0001, 0);
    checkOutput("t3_b_one", 32'(res), 32'h1234);
    applyStimulus(16'h0000, 16'hFFFF, 0);
    checkOutput("t3_a_zero", 32'(res), 32'h0000);
    applyStimulus(16'h00FF, 16'h0100, 1);
    checkOutput("t3_same_cycle_load", 32'(res), 32'hFF00);
    checkOutput("t3_same_cycle_done", done_cycle, LAT + 1);

    // Mid-run load/start with all-ones operands must not disturb the run.
    @(negedge clk);
    op_a_i = 16'h8000; op_b_i = 16'h0002; load_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0; start_i = 1'b0;
    repeat (3) @(negedge clk);
    op_a_i = 16'hFFFF; op_b_i = 16'hFFFF; load_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0; start_i = 1'b0;
    done_pulses = 0;
    res = '0;
    repeat (25) begin
      if (done_o) begin
        done_pulses++;
        res = result_o;
      end
      @(negedge clk);
    end
    checkOutput("t4_midrun_result", 32'(res), 32'h002B);
    checkOutput("t4_done_pulses", done_pulses, 1);
    applyStimulus(16'hFFFF, 16'hFFFF, 2);
    checkOutput("t4_operands_kept", 32'(res), 32'h002B);

    // Synchronous reset during cycle 8 of a run.
    @(negedge clk);
    op_a_i = 16'h1234; op_b_i = 16'h5678; load_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0; start_i = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("t5_rst_done", 32'(done_o), 32'd0);
    checkOutput("t5_rst_result", 32'(result_o), 32'h0);
    rst = 1'b0;
    done_pulses = 0;
    repeat (20) begin
      if (done_o) done_pulses++;
      @(negedge clk);
    end
    checkOutput("t5_no_done_after_rst", done_pulses, 0);
    applyStimulus(16'hFFFF, 16'hFFFF, 2);
    checkOutput("t5_operands_cleared", 32'(res), 32'h0);

    for (int n = 0; n < 200; n++) begin
      ra = operand_t'($urandom);
      rb = operand_t'($urandom);
      applyStimulus(ra, rb, n % 2);
      checkOutput($sformatf("t6_rand_%0d", n), 32'(res), 32'(gf_ref(ra, rb)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
